// File: rtl/dump_pkg.sv
// dump_pkg: state encoding, ASCII constants and nibble-to-ASCII helper for ram_ascii_dumper.
// Configuration macro: DUMP_CHECKSUM_EN adds the CKS state (trailing "X<hh>\r\n" checksum line).
package dump_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_DIG,
        S_SEP,
        S_CR,
        S_LF,
`ifdef DUMP_CHECKSUM_EN
        S_CKS,
`endif
        S_FIN
    } state_t;

    localparam logic [7:0] ZERO   = 8'h30;
    localparam logic [7:0] ONE    = 8'h31;
    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] CHAR_A = 8'h41;
    localparam logic [7:0] CHAR_X = 8'h58;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ZERO + {4'd0, nib};
        end
        return CHAR_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/dump_digit_gen.sv
// dump_digit_gen: holds one RAM word and produces its ASCII digits MSB first.
// Binary mode walks DATA_W bits; hex mode walks ceil(DATA_W/4) nibbles, zero-padded at the top.
module dump_digit_gen
    import dump_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              btn_clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              advance,
    input  logic              mode,
    output logic [7:0]        digit,
    output logic              last_digit
);

    localparam int NIB   = (DATA_W + 3) / 4;
    localparam int PAD_W = NIB * 4;

    logic [PAD_W-1:0] sreg;
    logic [6:0]       cnt;

    // Load a fresh word, or shift out one digit per accepted byte.
    always_ff @(posedge btn_clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= PAD_W'(data);
            cnt  <= '0;
        end else if (advance) begin
            sreg <= mode ? (sreg << 4) : (sreg << 1);
            cnt  <= cnt + 7'd1;
        end
    end

    // Current digit and end-of-word flag for the selected radix.
    always_comb begin
        digit      = '0;
        last_digit = 1'b0;
        if (mode) begin
            digit      = nib2ascii(sreg[PAD_W-1 -: 4]);
            last_digit = (cnt == 7'(NIB - 1));
        end else begin
            digit      = sreg[DATA_W-1] ? ONE : ZERO;
            last_digit = (cnt == 7'(DATA_W - 1));
        end
    end

endmodule

// File: rtl/ram_ascii_dumper.sv
// ram_ascii_dumper: on a start edge, reads RAM words 0..DEPTH-1 and streams them as ASCII
// (binary or hex) to a UART transmitter, WORDS_PER_LINE words per CR LF terminated line.
// Configuration macro: DUMP_CHECKSUM_EN appends "X<hh>\r\n", the XOR of all digit bytes.
// tx handshake: a byte moves on a cycle with tx_valid && tx_ready; while tx_valid is high and
// tx_ready low, tx_data and tx_valid hold; a new byte may be offered the cycle after a transfer.
module ram_ascii_dumper
    import dump_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int DEPTH          = 16,
    parameter int RD_LAT         = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              btn_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int                LC_W      = $clog2(WORDS_PER_LINE + 1);
    localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LC_W-1:0]   LINE_LAST = LC_W'(WORDS_PER_LINE - 1);
`ifdef DUMP_CHECKSUM_EN
    localparam state_t AFTER_DUMP = S_CKS;
`else
    localparam state_t AFTER_DUMP = S_FIN;
`endif

    state_t            state, next_state;
    logic              start_q;
    logic              mode_q;
    logic [ADDR_W-1:0] addr;
    logic [LC_W-1:0]   line_cnt;
    logic [2:0]        lat_cnt;
    logic              abort_pend;
    logic              start_edge;
    logic              busy_int;
    logic              last_addr;
    logic              line_full;
    logic              xfer;
    logic              load;
    logic [7:0]        digit;
    logic              last_digit;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        csum;
    logic [2:0]        cks_idx;
`endif

    assign start_edge = start && !start_q;
    assign busy_int   = (state != S_IDLE) && (state != S_FIN);
    assign last_addr  = (addr == LAST_ADDR);
    assign line_full  = (line_cnt == LINE_LAST);
    assign xfer       = tx_valid && tx_ready;
    assign load       = (state == S_WAIT) && (lat_cnt == LAT_LAST);
    assign busy       = busy_int;
    assign done       = (state == S_FIN);

    dump_digit_gen #(
        .DATA_W (DATA_W)
    ) u_digit (
        .btn_clk    (btn_clk),
        .rst        (rst),
        .load       (load),
        .data       (rd_data),
        .advance    ((state == S_DIG) && tx_ready),
        .mode       (mode_q),
        .digit      (digit),
        .last_digit (last_digit)
    );

    // State register plus the address, line, latency and abort bookkeeping.
    always_ff @(posedge btn_clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            mode_q     <= 1'b0;
            addr       <= '0;
            line_cnt   <= '0;
            lat_cnt    <= '0;
            abort_pend <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum       <= '0;
            cks_idx    <= '0;
`endif
        end else begin
            state   <= next_state;
            start_q <= start;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        mode_q     <= mode;
                        addr       <= '0;
                        line_cnt   <= '0;
                        abort_pend <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                S_RD:   lat_cnt <= '0;
                S_WAIT: lat_cnt <= lat_cnt + 3'd1;
                S_DIG: begin
                    if (xfer && last_digit) line_cnt <= line_cnt + LC_W'(1);
`ifdef DUMP_CHECKSUM_EN
                    if (xfer) csum <= csum ^ digit;
`endif
                end
                S_SEP: begin
                    if (xfer) addr <= addr + ADDR_W'(1);
                end
                S_LF: begin
                    if (xfer) begin
                        line_cnt <= '0;
                        if (!last_addr) addr <= addr + ADDR_W'(1);
`ifdef DUMP_CHECKSUM_EN
                        cks_idx  <= '0;
`endif
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_CKS: begin
                    if (xfer) cks_idx <= cks_idx + 3'd1;
                end
`endif
                S_FIN:   abort_pend <= 1'b0;
                default: ;
            endcase
            // An abort that arrives while a byte is stalled is remembered until it moves.
            if (busy_int && abort && tx_valid && !tx_ready) abort_pend <= 1'b1;
        end
    end

    // Next state and the RAM/transmitter outputs decoded from the current state.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        case (state)
            S_IDLE: if (start_edge) next_state = S_RD;
            S_RD: begin
                rd_en      = 1'b1;
                rd_addr    = addr;
                next_state = S_WAIT;
            end
            S_WAIT: if (lat_cnt == LAT_LAST) next_state = S_DIG;
            S_DIG: begin
                tx_valid = 1'b1;
                tx_data  = digit;
                if (tx_ready && last_digit) next_state = (line_full || last_addr) ? S_CR : S_SEP;
            end
            S_SEP: begin
                tx_valid = 1'b1;
                tx_data  = SPACE;
                if (tx_ready) next_state = S_RD;
            end
            S_CR: begin
                tx_valid = 1'b1;
                tx_data  = CR;
                if (tx_ready) next_state = S_LF;
            end
            S_LF: begin
                tx_valid = 1'b1;
                tx_data  = LF;
                if (tx_ready) next_state = last_addr ? AFTER_DUMP : S_RD;
            end
`ifdef DUMP_CHECKSUM_EN
            S_CKS: begin
                tx_valid = 1'b1;
                case (cks_idx)
                    3'd0:    tx_data = CHAR_X;
                    3'd1:    tx_data = nib2ascii(csum[7:4]);
                    3'd2:    tx_data = nib2ascii(csum[3:0]);
                    3'd3:    tx_data = CR;
                    default: tx_data = LF;
                endcase
                if (tx_ready && cks_idx == 3'd4) next_state = S_FIN;
            end
`endif
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // Abort ends the dump once no byte is left half-offered.
        if (busy_int && (abort || abort_pend) && (!tx_valid || tx_ready)) next_state = S_FIN;
    end

endmodule
